// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: shared states, MAC instruction codes, modes and
// the per-state registered control decode for the MAC sequencer.
package mac_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_GAP     = 3'd2,
    S_EXEC    = 3'd3,
    S_DRAIN   = 3'd4,
    S_DELIVER = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef struct packed {
    logic [1:0] inst_w;
    logic       l0_rd;
    logic       deliver;
    logic       hold;
    logic       busy;
    logic       done;
  } ctl_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic ctl_t decode(state_e s);
    ctl_t c;
    c.inst_w  = INST_NOP;
    c.l0_rd   = 1'b0;
    c.deliver = 1'b0;
    c.hold    = 1'b1;
    c.busy    = 1'b1;
    c.done    = 1'b0;
    unique case (s)
      S_IDLE: c.busy = 1'b0;
      S_LOAD: begin
        c.inst_w = INST_LOAD;
        c.l0_rd  = 1'b1;
        c.hold   = 1'b0;
      end
      S_GAP: c.hold = 1'b1;
      S_EXEC: begin
        c.inst_w = INST_EXEC;
        c.l0_rd  = 1'b1;
        c.hold   = 1'b0;
      end
      S_DRAIN: c.hold = 1'b0;
      S_DELIVER: begin
        c.deliver = 1'b1;
        c.hold    = 1'b0;
      end
      S_DONE: begin
        c.busy = 1'b0;
        c.done = 1'b1;
      end
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mac_seq_counter.sv
// mac_seq_counter: loadable down-counter, stops at zero.
// Ports: clk, reset, ld/ld_val (load wins), en (count), last (count==1).
module mac_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: MAC array tile-job sequencer (LOAD/GAP/EXEC/DRAIN/DELIVER).
// Ports: clk, reset, start, mode, exec_len, l0_empty in; l0_rd, inst_w,
// mac_tile_version, mac_deliver, hold_cq, busy, done out.
// MAC_SEQ_PERF_EN adds perf_cycles[31:0] and perf_stalls[15:0].
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [len_bw-1:0] exec_len,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [1:0]        inst_w,
  output logic              mac_tile_version,
  output logic              mac_deliver,
  output logic              hold_cq,
  output logic              busy,
  output logic              done
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_stalls
`endif
);

  localparam int CW = max_int(len_bw, $clog2(row + col));

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [len_bw-1:0] len_q, len_d;
  ctl_t              ctl_q, ctl_d;

  logic          cnt_ld, cnt_en, cnt_last;
  logic [CW-1:0] cnt_val;
  logic          feed, stall, acc;

  assign feed  = (state_q == S_LOAD) || (state_q == S_EXEC);
  assign stall = feed && l0_empty;
  assign acc   = feed && !l0_empty;

  mac_seq_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .ld     (cnt_ld),
    .ld_val (cnt_val),
    .en     (cnt_en),
    .last   (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    cnt_en  = acc || (state_q == S_DRAIN) ||
              (state_q == S_DELIVER);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          len_d  = exec_len;
          if (exec_len == '0) begin
            state_d = S_DONE;
          end else if (mode == MODE_OS) begin
            state_d = S_EXEC;
            cnt_ld  = 1'b1;
            cnt_val = CW'(exec_len);
          end else begin
            state_d = S_LOAD;
            cnt_ld  = 1'b1;
            cnt_val = CW'(col);
          end
        end
      end
      S_LOAD: begin
        if (acc && cnt_last) state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_EXEC;
        cnt_ld  = 1'b1;
        cnt_val = CW'(len_q);
      end
      S_EXEC: begin
        if (acc && cnt_last) begin
          state_d = S_DRAIN;
          cnt_ld  = 1'b1;
          cnt_val = CW'(row + col - 1);
        end
      end
      S_DRAIN: begin
        if (cnt_last) begin
          if (mode_q == MODE_OS) begin
            state_d = S_DELIVER;
            cnt_ld  = 1'b1;
            cnt_val = CW'(row);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DELIVER: begin
        if (cnt_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ctl_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_WS;
      len_q   <= '0;
      ctl_q   <= decode(S_IDLE);
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      ctl_q   <= ctl_d;
    end
  end

  // Phase outputs are registered; an empty L0 can only be seen in the
  // cycle it happens, so it masks the feed outputs directly.
  assign inst_w           = stall ? INST_NOP : ctl_q.inst_w;
  assign l0_rd            = ctl_q.l0_rd && !stall;
  assign hold_cq          = ctl_q.hold || stall;
  assign mac_deliver      = ctl_q.deliver;
  assign busy             = ctl_q.busy;
  assign done             = ctl_q.done;
  assign mac_tile_version = mode_q;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] pc_q, pc_d;
  logic [15:0] ps_q, ps_d;

  // Counts every cycle from the one after start through done.
  always_comb begin
    pc_d = pc_q;
    ps_d = ps_q;
    if (state_q == S_IDLE && start) begin
      pc_d = '0;
      ps_d = '0;
    end else if (state_q != S_IDLE) begin
      pc_d = pc_q + 32'd1;
      if (stall && ps_q != 16'hFFFF) ps_d = ps_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      ps_q <= '0;
    end else begin
      pc_q <= pc_d;
      ps_q <= ps_d;
    end
  end

  assign perf_cycles = pc_q;
  assign perf_stalls = ps_q;
`endif

endmodule
